btn_event_queue: RTL and testbench
==================================

# btn_event_queue

Memory-mapped input block that debounces the six board buttons and queues timestamped press/release events for the CPU. It sits upstream of the bus, alongside the timers and flash controller on the CPU clock. Its read data feeds the bus data mux in place of the plain level-sampling button reader. Software polls a status word and pops events instead of sampling raw levels.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable cycles required before the debounced level changes (10 ms at 27 MHz).
- `FIFO_DEPTH`, default 8: number of event entries; must be a power of two, at most 16.

Ports:
- `clk` in 1: CPU clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_n` in 6: raw button pins, active-low. Bit 0 down, 1 up, 2 left, 3 right, 4 btn1, 5 btn2.
- `ren` in 1: bus read enable for this block.
- `wen` in 1: bus write enable for this block.
- `address` in 8: byte address within the block.
- `data_in` in 32: bus write data.
- `data_out` out 32: registered read data.
- `irq` out 1: high while the FIFO is non-empty.

## Operation
- Each `btn_n` bit passes through a 2-FF synchronizer. Synchronizer flops reset to 1 (released).
- Debounce, per button:
  - The counter increments while the synchronized value differs from the debounced level, and clears on any cycle where they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the level toggles, the counter clears, and the button's pending bit is set.
  - Press pending is set when the level goes to 1; release pending when it goes to 0.
- Arbiter: each cycle, the lowest-index pending button is pushed and its pending bit cleared. Other pending buttons wait for later cycles.
- Pushed event word:
  - [31] = 1
  - [30] = press
  - [18:16] = button id
  - [15:0] = timestamp, or 0 (see Configuration)
- FIFO full on push: the event is dropped, the pending bit is cleared, and sticky `overflow` is set.
- Register map (other addresses read 0):
  - 0x00 read: [5:0] debounced levels, 1 = pressed.
  - 0x04 read: pop. Returns the head entry and removes it. Empty returns 0 and changes no state.
  - 0x08 read: status. [4:0] count, [8] overflow, [9] full.
  - 0x08 write: `data_in[8]`=1 clears `overflow`.
- The pop fires only on the first cycle of a `ren` assertion at 0x04 (`ren` & !`ren_q`). A `ren` held for several cycles therefore pops once.
- Writes to any other address are ignored.

## Timing
- Reset values:
  - `data_out` = 0, `irq` = 0.
  - Levels 0, counters 0, pending 0, count 0, `overflow` 0, timestamp 0.
- Pin edge to level change: 2 synchronizer cycles + `DEBOUNCE_CYCLES`.
- Level change to FIFO push: the next cycle when no other button is pending. Push to `irq` high: 1 cycle.
- Read latency: `data_out` is valid the cycle after `ren`. It holds its value until the next read.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, a simultaneous pop frees the slot, so the push is accepted and no overflow is set.
- Overflow set and clear in the same cycle: set wins.
- Pointers wrap modulo `FIFO_DEPTH`. Count ranges 0..`FIFO_DEPTH`.
- Reset asserted mid-debounce or mid-queue discards all state immediately.

## Configuration
- `BTN_TIMESTAMP_EN` defined: a 16-bit free-running counter at `clk`/27 (1 µs) is captured into event [15:0] at push. The counter wraps at 0xFFFF and resets to 0.
- Not defined: the counter is not built and [15:0] reads 0.

## Structure
- Shared package `btn_pkg` holds:
  - button id constants
  - register offsets 0x00/0x04/0x08
  - event field positions
  - status bit positions
- Sub-module `btn_debounce`: synchronizer, counter and level for one button, with a one-cycle `rise`/`fall` strobe. Instantiated six times.
- FIFO, arbiter and register decode are written inline.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4.
- Press down for 10 cycles, then release -> level 0x00 reads 0x01 after 6 cycles. Pops return 0xC000_0000 then 0x8000_0000, then 0.
- Glitch up low for 3 cycles -> no level change, count stays 0, `irq` stays 0.
- Press btn1 and left on the same cycle -> two pops return id 2 first (0xC002_xxxx), then id 4 (0xC004_xxxx).
- Nine presses without popping, `FIFO_DEPTH`=8 -> status 0x308. Writing 0x100 to 0x08 gives 0x208.
- Hold `ren` at 0x04 for 5 cycles with 2 entries queued -> count drops by exactly 1.
- Full FIFO with push and pop on the same cycle -> count stays 8, overflow stays 0. Reset asserted mid-stream gives status 0 and `data_out` 0 asynchronously.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared ids, register offsets and field positions for the button event queue
package btn_pkg;
    localparam int NUM_BTN = 6;

    typedef enum logic [2:0] {
        BTN_DOWN  = 3'd0,
        BTN_UP    = 3'd1,
        BTN_LEFT  = 3'd2,
        BTN_RIGHT = 3'd3,
        BTN_1     = 3'd4,
        BTN_2     = 3'd5
    } btn_id_e;

    localparam logic [7:0] REG_LEVEL  = 8'h00;
    localparam logic [7:0] REG_POP    = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h08;

    localparam int EV_VALID_BIT = 31;
    localparam int EV_PRESS_BIT = 30;
    localparam int EV_ID_LSB    = 16;
    localparam int EV_TS_LSB    = 0;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_OVF_BIT   = 8;
    localparam int ST_FULL_BIT  = 9;

    function automatic logic [31:0] make_event(input logic press, input logic [2:0] id,
                                               input logic [15:0] ts);
        logic [31:0] ev;
        ev                   = '0;
        ev[EV_VALID_BIT]     = 1'b1;
        ev[EV_PRESS_BIT]     = press;
        ev[EV_ID_LSB +: 3]   = id;
        ev[EV_TS_LSB +: 16]  = ts;
        return ev;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: 2-FF synchronizer, stability counter and debounced level
// rise_o/fall_o pulse in the cycle whose clock edge flips the level.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          differ, expire;

    assign differ = (~sync2_q) != level_q;
    assign expire = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            if (!differ) begin
                cnt_q <= '0;
            end else if (expire) begin
                cnt_q   <= '0;
                level_q <= ~level_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = expire & ~level_q;
    assign fall_o  = expire & level_q;
endmodule

// File: rtl/btn_event_queue.sv
// rtl/btn_event_queue.sv - debounced buttons feeding a popped event FIFO behind a small register map
// Define BTN_TIMESTAMP_EN to stamp events with a 1 us free-running counter (clk/27).
module btn_event_queue
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  btn_n,
    input  logic        ren,
    input  logic        wen,
    input  logic [7:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        irq
);
    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    logic [NUM_BTN-1:0] level, rise, fall;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .btn_n_i (btn_n[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    logic [15:0] ts;
`ifdef BTN_TIMESTAMP_EN
    logic [4:0]  presc_q;
    logic [15:0] ts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            ts_q    <= '0;
        end else if (presc_q == 5'd26) begin
            presc_q <= '0;
            ts_q    <= ts_q + 16'd1;
        end else begin
            presc_q <= presc_q + 5'd1;
        end
    end
    assign ts = ts_q;
`else
    assign ts = '0;
`endif

    logic [NUM_BTN-1:0] pend_q, kind_q;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [4:0]         count_q;
    logic               ovf_q, ren_q, irq_q;
    logic [31:0]        data_out_q;
    logic [31:0]        mem_q [FIFO_DEPTH];

    logic [NUM_BTN-1:0] grant;
    logic               push_req, push_press;
    logic [2:0]         push_id;

    // Fixed priority: the lowest-index pending button wins this cycle.
    always_comb begin
        grant      = '0;
        push_req   = 1'b0;
        push_press = 1'b0;
        push_id    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (pend_q[i] && !push_req) begin
                push_req   = 1'b1;
                grant[i]   = 1'b1;
                push_press = kind_q[i];
                push_id    = 3'(i);
            end
        end
    end

    logic        full, empty, rd_first, pop, push_ok, ovf_set, ovf_clr;
    logic [31:0] status, rd_value;
    logic        rd_load;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == 5'd0);
    assign rd_first = ren & ~ren_q;
    assign pop      = rd_first & (address == REG_POP) & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;
    assign ovf_clr  = wen & (address == REG_STATUS) & data_in[ST_OVF_BIT];

    logic unused_data_in;
    assign unused_data_in = ^{data_in[31:ST_OVF_BIT+1], data_in[ST_OVF_BIT-1:0]};

    always_comb begin
        status                    = '0;
        status[ST_COUNT_LSB +: 5] = count_q;
        status[ST_OVF_BIT]        = ovf_q;
        status[ST_FULL_BIT]       = full;
    end

    always_comb begin
        rd_load  = ren;
        rd_value = '0;
        case (address)
            REG_LEVEL:  rd_value = {26'b0, level};
            REG_POP: begin
                rd_load  = rd_first;
                rd_value = empty ? 32'h0 : mem_q[rd_ptr_q];
            end
            REG_STATUS: rd_value = status;
            default:    rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            kind_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ren_q      <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            // A fresh level change overrides the grant of an older event for that button.
            pend_q <= (pend_q & ~grant) | rise | fall;
            kind_q <= (kind_q & ~(rise | fall)) | rise;
            ren_q  <= ren;
            irq_q  <= ~empty;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop)      count_q <= count_q + 5'd1;
            else if (!push_ok && pop) count_q <= count_q - 5'd1;
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
            if (rd_load) data_out_q <= rd_value;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= make_event(push_press, push_id, ts);
    end

    assign data_out = data_out_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_btn_event_queue.sv
// tb/tb_btn_event_queue.sv - directed and randomized checks of btn_event_queue against a queue model
module tb_btn_event_queue;
    localparam int D     = 4;
    localparam int DEPTH = 8;
`ifdef BTN_TIMESTAMP_EN
    localparam logic [31:0] EV_MASK = 32'hFFFF_0000;
`else
    localparam logic [31:0] EV_MASK = 32'hFFFF_FFFF;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  btn_n = 6'h3F;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        irq;

    always #5 clk = ~clk;

    btn_event_queue #(
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_n    (btn_n),
        .ren      (ren),
        .wen      (wen),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: pressed-pin history, per-button level and last toggle edge,
    // pending events and the event queue itself.
    logic [5:0]  hist [$];
    int          edge_n;
    logic [5:0]  m_level, m_pend, m_kind;
    int          m_last [6];
    logic [31:0] m_q [$];
    logic        m_ovf, m_ren_prev, m_irq;
    logic [31:0] m_dout, m_mask;

    task automatic model_reset();
        hist.delete();
        m_q.delete();
        edge_n     = 0;
        m_level    = '0;
        m_pend     = '0;
        m_kind     = '0;
        m_ovf      = 1'b0;
        m_ren_prev = 1'b0;
        m_irq      = 1'b0;
        m_dout     = '0;
        m_mask     = '1;
        for (int i = 0; i < 6; i++) m_last[i] = -1;
    endtask

    // Pin state seen by the debounce logic at edge x (two edges of synchronizer delay).
    function automatic logic [5:0] s_at(input int x);
        return (x >= 2) ? hist[x-2] : 6'b0;
    endfunction

    function automatic logic [31:0] status_word(input int n, input logic ovf);
        logic [31:0] w;
        w      = '0;
        w[4:0] = n[4:0];
        w[8]   = ovf;
        w[9]   = (n == DEPTH);
        return w;
    endfunction

    task automatic model_edge();
        int          x, sz;
        logic        ren_first, pop_fire, push, ovf_set, all_diff;
        logic [5:0]  s;
        logic [31:0] word;
        x = edge_n;
        hist.push_back(~btn_n);
        sz        = m_q.size();
        m_irq     = (sz != 0);
        ren_first = ren && !m_ren_prev;
        pop_fire  = ren_first && (address == 8'h04) && (sz > 0);
        if (ren) begin
            case (address)
                8'h00: begin m_dout = {26'b0, m_level}; m_mask = '1; end
                8'h04: if (ren_first) begin
                    m_dout = pop_fire ? m_q[0] : 32'h0;
                    m_mask = pop_fire ? EV_MASK : 32'hFFFF_FFFF;
                end
                8'h08: begin m_dout = status_word(sz, m_ovf); m_mask = '1; end
                default: begin m_dout = 32'h0; m_mask = '1; end
            endcase
        end
        push = 1'b0;
        word = '0;
        for (int i = 0; i < 6; i++) begin
            if (m_pend[i] && !push) begin
                push      = 1'b1;
                word      = {1'b1, m_kind[i], 11'b0, 3'(i), 16'h0};
                m_pend[i] = 1'b0;
            end
        end
        if (pop_fire) void'(m_q.pop_front());
        ovf_set = 1'b0;
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(word);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (wen && address == 8'h08 && data_in[8]) m_ovf = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (x - m_last[i] >= D) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) begin
                    s = s_at(x - k);
                    if (s[i] == m_level[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    m_last[i]  = x;
                    m_pend[i]  = 1'b1;
                    m_kind[i]  = m_level[i];
                end
            end
        end
        m_ren_prev = ren;
        edge_n++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        check("data_out", data_out & m_mask, m_dout & m_mask);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        ren     = 1'b1;
        address = a;
        step();
        d   = data_out;
        ren = 1'b0;
        step();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] v);
        wen     = 1'b1;
        address = a;
        data_in = v;
        step();
        wen = 1'b0;
        step();
    endtask

    task automatic drain();
        logic [31:0] d;
        int guard;
        guard = 0;
        while (m_q.size() > 0 && guard < 40) begin
            bus_read(8'h04, d);
            guard++;
        end
        check("drain_count", 32'(m_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          b;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        bus_read(8'h08, d);
        check("reset_status", d, 32'h0);
        bus_read(8'h00, d);
        check("reset_level", d, 32'h0);

        // press down: level flips on the sixth edge after the pin change
        btn_n[0] = 1'b0;
        idle(5);
        bus_read(8'h00, d);
        check("t1_level_before", d, 32'h0);
        bus_read(8'h00, d);
        check("t1_level_after", d, 32'h1);
        idle(1);
        btn_n[0] = 1'b1;
        idle(12);
        bus_read(8'h04, d);
        check("t1_pop_press", d & EV_MASK, 32'hC000_0000);
        bus_read(8'h04, d);
        check("t1_pop_release", d & EV_MASK, 32'h8000_0000);
        bus_read(8'h04, d);
        check("t1_pop_empty", d, 32'h0);

        // 3-cycle glitch on up never reaches the debounced level
        btn_n[1] = 1'b0;
        idle(3);
        btn_n[1] = 1'b1;
        idle(10);
        check("t2_irq", {31'b0, irq}, 32'h0);
        bus_read(8'h08, d);
        check("t2_status", d, 32'h0);
        bus_read(8'h00, d);
        check("t2_level", d, 32'h0);

        // simultaneous presses drain lowest id first
        btn_n[2] = 1'b0;
        btn_n[4] = 1'b0;
        idle(8);
        check("t3_irq", {31'b0, irq}, 32'h1);
        bus_read(8'h04, d);
        check("t3_pop_left", d & EV_MASK, 32'hC002_0000);
        bus_read(8'h04, d);
        check("t3_pop_btn1", d & EV_MASK, 32'hC004_0000);
        btn_n[2] = 1'b1;
        btn_n[4] = 1'b1;
        idle(10);
        drain();

        // ren held five cycles pops exactly once
        btn_n[5] = 1'b0;
        idle(8);
        btn_n[5] = 1'b1;
        idle(8);
        bus_read(8'h08, d);
        check("t4_status_before", d, 32'h2);
        ren     = 1'b1;
        address = 8'h04;
        idle(5);
        ren = 1'b0;
        step();
        bus_read(8'h08, d);
        check("t4_status_after", d, 32'h1);
        drain();

        // nine events into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            btn_n[3] = ~btn_n[3];
            idle(8);
        end
        bus_read(8'h08, d);
        check("t5_status_ovf", d, 32'h308);
        bus_write(8'h08, 32'h100);
        bus_read(8'h08, d);
        check("t5_status_clr", d, 32'h208);

        // push and pop on the same edge while full
        btn_n[3] = 1'b1;
        idle(6);
        bus_read(8'h04, d);
        check("t6_pop_head", d & EV_MASK, 32'hC003_0000);
        bus_read(8'h08, d);
        check("t6_status", d, 32'h208);

        // asynchronous reset in the middle of a full queue
        reset = 1'b1;
        #2;
        check("t7_reset_data_out", data_out, 32'h0);
        check("t7_reset_irq", {31'b0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        bus_read(8'h08, d);
        check("t7_status", d, 32'h0);

        // randomized pins and bus traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(2) == 0) begin
                b = int'($urandom_range(5));
                btn_n[b] = ~btn_n[b];
            end
            ren = ($urandom_range(2) == 0);
            case ($urandom_range(3))
                0: address = 8'h00;
                1: address = 8'h04;
                2: address = 8'h08;
                default: address = 8'h0C;
            endcase
            wen     = ($urandom_range(9) == 0);
            data_in = $urandom;
            step();
        end
        ren = 1'b0;
        wen = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
